// File: rtl/instr_mem_loader_pkg.sv
// instr_mem_loader_pkg: shared widths, capacity, FSM state encoding and byte-lane select
package instr_mem_loader_pkg;
    localparam int WORD = 32;
    localparam int BYTE = 8;
    localparam int LINE = 42;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCEPT = 2'd1,
        WRITE  = 2'd2,
        DONE   = 2'd3
    } state_e;

    // Big-endian lane select: k=0 returns the most significant byte.
    function automatic logic [BYTE-1:0] byte_sel(input logic [WORD-1:0] w, input logic [1:0] k);
        return w[WORD-1-BYTE*int'(k) -: BYTE];
    endfunction
endpackage

// File: rtl/instr_mem_loader_if.sv
// instr_mem_loader_if: word stream (valid/ready/data/last) plus byte memory write port
//   master: drives in_valid/in_data/in_last, observes in_ready and the memory write port
//   slave : the loader; accepts words and drives mem_we/mem_addr/mem_wdata
interface instr_mem_loader_if;
    import instr_mem_loader_pkg::*;
    logic            in_valid;
    logic            in_ready;
    logic [WORD-1:0] in_data;
    logic            in_last;
    logic            mem_we;
    logic [WORD-1:0] mem_addr;
    logic [BYTE-1:0] mem_wdata;
    modport master (output in_valid, in_data, in_last, input in_ready, mem_we, mem_addr, mem_wdata);
    modport slave  (input in_valid, in_data, in_last, output in_ready, mem_we, mem_addr, mem_wdata);
endinterface

// File: rtl/instr_mem_loader_byte_serializer.sv
// instr_byte_serializer: latches a word and emits its 4 bytes MSB-first on consecutive cycles
//   load_i      : latch word_i and start at address base_i
//   we_o/addr_o/wdata_o : registered byte write port; addr held when idle
//   done_o      : high during the cycle that carries byte 3
module instr_byte_serializer
    import instr_mem_loader_pkg::*;
#(
    parameter logic [WORD-1:0] BASE_ADDR = '0
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            load_i,
    input  logic [WORD-1:0] word_i,
    input  logic [WORD-1:0] base_i,
    output logic            we_o,
    output logic [WORD-1:0] addr_o,
    output logic [BYTE-1:0] wdata_o,
    output logic            done_o
);
    logic [WORD-1:0] word_q, addr_q;
    logic [BYTE-1:0] wdata_q;
    logic [1:0]      k_q, k_d;
    logic            we_q;

    assign k_d = k_q + 2'd1;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            word_q  <= '0;
            addr_q  <= BASE_ADDR;
            wdata_q <= '0;
            k_q     <= '0;
            we_q    <= 1'b0;
        end else if (load_i) begin
            word_q  <= word_i;
            addr_q  <= base_i;
            wdata_q <= byte_sel(word_i, 2'd0);
            k_q     <= '0;
            we_q    <= 1'b1;
        end else if (we_q) begin
            if (k_q == 2'd3) begin
                we_q <= 1'b0;
            end else begin
                k_q     <= k_d;
                addr_q  <= addr_q + WORD'(1);
                wdata_q <= byte_sel(word_q, k_d);
            end
        end
    end

    assign we_o    = we_q;
    assign addr_o  = addr_q;
    assign wdata_o = wdata_q;
    assign done_o  = we_q && (k_q == 2'd3);
endmodule

// File: rtl/instr_mem_loader.sv
// instr_mem_loader: loads a word stream into byte memory big-endian while holding the CPU
//   start_i      : one-cycle pulse, begins a session from IDLE or DONE
//   bus          : word stream in, byte write port out
//   cpu_hold_o   : high while a session is active
//   done_o       : high after a session completes, until the next start
//   overflow_o   : session ended at capacity without in_last
//   word_count_o : words written in the current or last session
module instr_mem_loader #(
    parameter int                                 LINE      = instr_mem_loader_pkg::LINE,
    parameter logic [instr_mem_loader_pkg::WORD-1:0] BASE_ADDR = '0
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       start_i,
    instr_mem_loader_if.slave          bus,
    output logic                       cpu_hold_o,
    output logic                       done_o,
    output logic                       overflow_o,
    output logic [$clog2(LINE+1)-1:0]  word_count_o
);
    import instr_mem_loader_pkg::*;
    localparam int CW = $clog2(LINE+1);

    state_e          state_q;
    logic [WORD-1:0] ptr_q;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic            last_q, hold_q, done_q, ovf_q;
    logic            load, ser_done;

    assign bus.in_ready = (state_q == ACCEPT);
    assign load         = bus.in_ready && bus.in_valid;
    assign cnt_d        = cnt_q + CW'(1);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            ptr_q   <= BASE_ADDR;
            cnt_q   <= '0;
            last_q  <= 1'b0;
            hold_q  <= 1'b0;
            done_q  <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            case (state_q)
                IDLE, DONE: if (start_i) begin
                    state_q <= ACCEPT;
                    ptr_q   <= BASE_ADDR;
                    cnt_q   <= '0;
                    hold_q  <= 1'b1;
                    done_q  <= 1'b0;
                    ovf_q   <= 1'b0;
                end
                ACCEPT: if (bus.in_valid) begin
                    last_q  <= bus.in_last;
                    state_q <= WRITE;
                end
                WRITE: if (ser_done) begin
                    ptr_q <= ptr_q + WORD'(4);
                    cnt_q <= cnt_d;
                    // in_last takes priority, so a last word that fills capacity is not an overflow
                    if (last_q || cnt_d == CW'(LINE)) begin
                        state_q <= DONE;
                        done_q  <= 1'b1;
                        hold_q  <= 1'b0;
                        ovf_q   <= !last_q;
                    end else begin
                        state_q <= ACCEPT;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    instr_byte_serializer #(.BASE_ADDR(BASE_ADDR)) u_ser (
        .clk     (clk),
        .rst_n   (rst_n),
        .load_i  (load),
        .word_i  (bus.in_data),
        .base_i  (ptr_q),
        .we_o    (bus.mem_we),
        .addr_o  (bus.mem_addr),
        .wdata_o (bus.mem_wdata),
        .done_o  (ser_done)
    );

    assign cpu_hold_o   = hold_q;
    assign done_o       = done_q;
    assign overflow_o   = ovf_q;
    assign word_count_o = cnt_q;
endmodule

// File: doc/instr_mem_loader.md
Name: instr_mem_loader

Overview:
- Writer side of the byte-addressed instruction memory. It accepts 32-bit instruction words over a valid/ready stream, for example from a UART or testbench host.
- Each word is written as four sequential big-endian byte writes into the memory's byte write port: MSB goes to the lowest address, matching the fetch-side byte order {mem[a],mem[a+1],mem[a+2],mem[a+3]}.
- While loading, it holds the pipeline in stall via cpu_hold, then releases it.

Parameters:
- WORD, 32, instruction width in bits.
- BYTE, 8, memory cell width in bits.
- LINE, 42, memory capacity in words; the memory holds 4*LINE bytes.
- BASE_ADDR, 0, byte address of the first byte written.

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous active-low reset.
- start  input  1  one-cycle pulse; begins a load session.
- in_valid  input  1  in_data/in_last are valid.
- in_ready  output  1  loader can accept a word this cycle.
- in_data  input  WORD  instruction word.
- in_last  input  1  marks the final word of the program.
- mem_we  output  1  byte write enable.
- mem_addr  output  WORD  byte write address.
- mem_wdata  output  BYTE  byte to write.
- cpu_hold  output  1  high while a session is active; the pipeline stalls and the PC is held.
- done  output  1  high after a session completes; stays high until the next start.
- overflow  output  1  session ended because capacity was reached without in_last.
- word_count  output  $clog2(LINE+1)  words written in the current or last session.

Behaviour:
- Reset (async, rst_n=0): state IDLE; in_ready=0, mem_we=0, mem_addr=BASE_ADDR, mem_wdata=0, cpu_hold=0, done=0, overflow=0, word_count=0. Any partial word is abandoned; bytes already written are not rolled back.
- States: IDLE, ACCEPT, WRITE, DONE.
- IDLE or DONE, start=1 -> ACCEPT:
  - Clear done, overflow and word_count.
  - Set the address pointer to BASE_ADDR.
  - cpu_hold=1 from the next cycle.
- ACCEPT: in_ready=1, mem_we=0. On in_valid&in_ready, latch in_data and in_last, reset the byte index to 0, then go to WRITE.
- WRITE: in_ready=0 and mem_we=1 for exactly 4 consecutive cycles, byte index k=0..3:
  - mem_addr = pointer + k.
  - mem_wdata = word[WORD-1-8k -: 8], so k=0 carries bits 31:24.
  - After k=3: pointer += 4 and word_count += 1.
- Exit from WRITE after k=3:
  - If the latched in_last=1 -> DONE.
  - Else if word_count (new value) == LINE -> DONE with overflow=1.
  - Else -> ACCEPT.
- Timing: a handshake at edge T gives byte writes on edges T+1..T+4. The next in_ready rises in the cycle after T+4. Throughput is 1 word per 5 cycles.
- DONE: done=1, cpu_hold=0, in_ready=0. Holds until the next start.
- start during ACCEPT or WRITE: ignored, no restart.
- in_valid outside ACCEPT: ignored; the data is not consumed.
- A word with in_last=1 that also fills capacity -> DONE with overflow=0.
- mem_addr is held at its last value when mem_we=0. Address arithmetic is WORD-bit unsigned and never exceeds BASE_ADDR+4*LINE-1.
- All outputs are registered except in_ready, which is decoded from state.

Decomposition:
- Shared package (project params include): WORD=32, BYTE=8, LINE=42, the state encoding localparams, and a byte-lane select function (word, k) -> byte.
- One natural sub-module: instr_byte_serializer. It latches a word, emits 4 big-endian bytes with addresses, and pulses done after byte 3. The FSM in instr_mem_loader owns the handshake, counters and flags.

Test Plan:
- Reset mid-WRITE: assert rst_n=0 after byte 1 of word 0x8C220004 -> all outputs return to reset values immediately; no further mem_we.
- Single word: start, send 0x20080005 with in_last=1 -> bytes 0x20,0x08,0x00,0x05 at addresses 0..3 on 4 consecutive cycles; done=1, word_count=1, cpu_hold falls.
- Three words with valid gaps (0x01095020, 0xAC0A0000, 0x08000000 last) -> 12 bytes at addresses 0..11 in big-endian order; in_ready low during each WRITE burst; word_count=3.
- Capacity: LINE=4, send 5 words with no in_last -> 16 bytes written; overflow=1, done=1; the 5th word is never accepted (in_ready stays 0).
- start pulsed during WRITE -> ignored; session completes normally. A second start in DONE -> done clears; loading restarts from BASE_ADDR with word_count=0.
- Readback: load a 42-word image, then read it through the fetch-side memory model at addresses 0,4,...,164 -> each fetched instruction equals the sent word.
